// File: rtl/tx_queue.sv
// tx_queue: byte FIFO feeding a UART transmitter
// first-word-fall-through head, sticky overflow, synchronous flush
module tx_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_stb,
    input  logic [7:0]               in_dat,
    output logic                     in_rdy,
    output logic                     out_stb,
    output logic [7:0]               out_dat,
    input  logic                     out_rdy,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PONE = 1;
    localparam logic [AW:0]   CONE = 1;
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign in_rdy  = (count != FULL);
    assign out_stb = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign level   = count;

    // handshakes qualified by pre-edge state; flush suppresses both
    always_comb begin
        push = in_stb && in_rdy && !flush;
        pop  = out_stb && out_rdy && !flush;
    end

    // storage array, intentionally left unreset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_dat;
    end

    // pointers, count and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PONE;
            if (pop)
                rd_ptr <= rd_ptr + PONE;
            case ({push, pop})
                2'b10:   count <= count + CONE;
                2'b01:   count <= count - CONE;
                default: count <= count;
            endcase
            if (in_stb && !in_rdy)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_queue.sv
// tb_tx_queue: directed checks of the transmit byte queue
// immediate assertions with hand-computed expectations
module tb_tx_queue;

    logic       clk;
    logic       rst;
    logic       in_stb;
    logic [7:0] in_dat;
    logic       in_rdy;
    logic       out_stb;
    logic [7:0] out_dat;
    logic       out_rdy;
    logic       flush;
    logic [4:0] level;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    tx_queue #(.DEPTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_stb  (in_stb),
        .in_dat  (in_dat),
        .in_rdy  (in_rdy),
        .out_stb (out_stb),
        .out_dat (out_dat),
        .out_rdy (out_rdy),
        .flush   (flush),
        .level   (level),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        in_stb = 1'b1;
        in_dat = d;
        tick();
        in_stb = 1'b0;
    endtask

    task automatic pop_byte();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [3];
        seq = '{8'h55, 8'hA3, 8'h0F};
        rst = 1'b0;
        in_stb = 1'b0;
        in_dat = 8'h00;
        out_rdy = 1'b0;
        flush = 1'b0;

        // reset state
        #12;
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_stb", 32'(out_stb), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // basic order, one-cycle push latency
        push_byte(8'h55);
        chk("lat_out_stb", 32'(out_stb), 32'd1);
        chk("lat_level", 32'(level), 32'd1);
        push_byte(8'hA3);
        push_byte(8'h0F);
        chk("ord_level", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("ord_dat", 32'(out_dat), 32'(seq[i]));
            chk("ord_lvl", 32'(level), 32'(3 - i));
            pop_byte();
        end
        chk("ord_empty_lvl", 32'(level), 32'd0);
        chk("ord_empty_stb", 32'(out_stb), 32'd0);

        // empty pop must not underflow
        pop_byte();
        chk("uflow_level", 32'(level), 32'd0);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            chk("fill_rdy", 32'(in_rdy), 32'd1);
            push_byte(8'(i));
        end
        chk("full_rdy", 32'(in_rdy), 32'd0);
        chk("full_level", 32'(level), 32'd16);
        push_byte(8'hEE);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_dat", 32'(out_dat), 32'(i));
            pop_byte();
        end
        chk("drain_level", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ovf", 32'(ovf), 32'd0);

        // streaming with wrap: push and pop every cycle
        out_rdy = 1'b1;
        in_stb = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_dat = 8'(8'h80 + k);
            if (k > 0)
                chk("wrap_dat", 32'(out_dat), 32'(8'h80 + k - 1));
            tick();
            chk("wrap_level", 32'(level), 32'd1);
        end
        in_stb = 1'b0;
        chk("wrap_last", 32'(out_dat), 32'h00A7);
        tick();
        out_rdy = 1'b0;
        chk("wrap_end", 32'(level), 32'd0);

        // full-edge race: pop honoured, push refused
        for (int i = 0; i < 16; i++)
            push_byte(8'(8'h10 + i));
        chk("race_pre", 32'(level), 32'd16);
        in_stb = 1'b1;
        in_dat = 8'hEE;
        out_rdy = 1'b1;
        tick();
        in_stb = 1'b0;
        out_rdy = 1'b0;
        chk("race_level", 32'(level), 32'd15);
        chk("race_ovf", 32'(ovf), 32'd1);
        for (int i = 1; i < 16; i++) begin
            chk("race_dat", 32'(out_dat), 32'(8'h10 + i));
            pop_byte();
        end
        chk("race_empty", 32'(out_stb), 32'd0);

        // flush beats push and pop
        for (int i = 0; i < 5; i++)
            push_byte(8'(8'h30 + i));
        chk("fl_pre", 32'(level), 32'd5);
        flush = 1'b1;
        in_stb = 1'b1;
        in_dat = 8'h77;
        out_rdy = 1'b1;
        tick();
        flush = 1'b0;
        in_stb = 1'b0;
        out_rdy = 1'b0;
        chk("fl_level", 32'(level), 32'd0);
        chk("fl_ovf", 32'(ovf), 32'd0);
        chk("fl_stb", 32'(out_stb), 32'd0);

        // asynchronous reset mid-cycle
        for (int i = 0; i < 7; i++)
            push_byte(8'(8'h40 + i));
        chk("ar_pre", 32'(level), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_rdy", 32'(in_rdy), 32'd1);
        chk("ar_stb", 32'(out_stb), 32'd0);
        chk("ar_level", 32'(level), 32'd0);
        #1;
        rst = 1'b1;
        push_byte(8'h4F);
        chk("ar_first", 32'(level), 32'd1);
        chk("ar_dat", 32'(out_dat), 32'h004F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
